// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit multiply/divide unit with HI/LO result registers.
// One operation at a time; 32 iterations in BUSY, result loaded on the edge into DONE.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i             request a new operation (accepted in IDLE only)
//   op_i[1:0]           0=MULT, 1=MULTU, 2=DIV, 3=DIVU
//   data1_i[31:0]       multiplicand / dividend
//   data2_i[31:0]       multiplier / divisor
//   hi_we_i, lo_we_i    mthi / mtlo write enables (honoured in IDLE only)
//   wdata_i[31:0]       mthi / mtlo write data
//   busy_o              high whenever the FSM is not IDLE
//   done_o              one-cycle pulse in the DONE state
//   hi_o, lo_o          HI / LO architectural registers
module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DLEN  = 2 * XLEN;
  localparam int unsigned CNT_W = 5;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand magnitude or divisor magnitude
  logic [XLEN-1:0]   dvd_q, dvd_d;       // raw dividend, returned on divide by zero
  logic [DLEN-1:0]   acc_q, acc_d;       // mul: {partial, multiplier}; div: {remainder, quotient}
  logic              neg_q, neg_d;       // result (product / quotient) needs negation
  logic              rem_neg_q, rem_neg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;

  // Operand magnitudes at start acceptance; op_i[0]=0 selects the signed ops.
  logic            signed_op;
  logic [XLEN-1:0] mag1, mag2;

  assign signed_op = ~op_i[0];
  assign mag1 = (signed_op && data1_i[XLEN-1]) ? (~data1_i + XLEN'(1)) : data1_i;
  assign mag2 = (signed_op && data2_i[XLEN-1]) ? (~data2_i + XLEN'(1)) : data2_i;

  // Shift-add multiply step: add multiplicand into upper half when LSB set, then shift right.
  logic [XLEN:0]   mul_sum;
  logic [DLEN-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[DLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : (XLEN+1)'(0));
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide step: shift next dividend bit into the remainder, subtract if it fits.
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_sub;
  logic            div_ge;
  logic [XLEN-1:0] div_rem;
  logic [DLEN-1:0] div_next;

  assign div_shift = {acc_q[DLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_sub   = div_shift - {1'b0, opnd_q};
  assign div_rem   = div_ge ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};

  // Final sign fix-ups, applied to the value produced by the last iteration.
  logic [DLEN-1:0] prod_res;
  logic [XLEN-1:0] quo_raw, rem_raw, quo_res, rem_res;
  logic            div_zero;

  assign prod_res = neg_q ? (~mul_next + DLEN'(1)) : mul_next;
  assign quo_raw  = div_next[XLEN-1:0];
  assign rem_raw  = div_next[DLEN-1:XLEN];
  assign quo_res  = neg_q ? (~quo_raw + XLEN'(1)) : quo_raw;
  assign rem_res  = rem_neg_q ? (~rem_raw + XLEN'(1)) : rem_raw;
  assign div_zero = (opnd_q == XLEN'(0));

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    dvd_d     = dvd_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hi_we_i) hi_d = wdata_i;
        if (lo_we_i) lo_d = wdata_i;
        if (start_i) begin
          state_d   = ST_BUSY;
          cnt_d     = '0;
          op_d      = op_i;
          dvd_d     = data1_i;
          opnd_d    = op_i[1] ? mag2 : mag1;
          acc_d     = {XLEN'(0), (op_i[1] ? mag1 : mag2)};
          neg_d     = signed_op & (data1_i[XLEN-1] ^ data2_i[XLEN-1]);
          rem_neg_d = signed_op & data1_i[XLEN-1];
        end
      end

      ST_BUSY: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          if (!op_q[1]) begin
            hi_d = prod_res[DLEN-1:XLEN];
            lo_d = prod_res[XLEN-1:0];
          end else if (div_zero) begin
            hi_d = dvd_q;
            lo_d = '1;
          end else begin
            hi_d = rem_res;
            lo_d = quo_res;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      opnd_q    <= '0;
      dvd_q     <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      dvd_q     <= dvd_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: the driver pushes expected HI/LO and the
// expected done cycle for each accepted operation; a monitor pops on done_o.
module tb_mul_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        hi_we_i;
  logic        lo_we_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  mul_div_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .op_i    (op_i),
    .data1_i (data1_i),
    .data2_i (data2_i),
    .hi_we_i (hi_we_i),
    .lo_we_i (lo_we_i),
    .wdata_i (wdata_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain signed/unsigned arithmetic on 64-bit values.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint      sa, sb, sq, sr;
    logic [63:0] v, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h  = '0;
    l  = '0;
    case (op)
      2'd0: begin
        v = 64'(sa * sb);
        h = v[63:32];
        l = v[31:0];
      end
      2'd1: begin
        v = {32'd0, a} * {32'd0, b};
        h = v[63:32];
        l = v[31:0];
      end
      2'd2: begin
        if (b == 32'd0) begin
          h = a;
          l = 32'hFFFF_FFFF;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          q  = 64'(sq);
          r  = 64'(sr);
          h  = r[31:0];
          l  = q[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin
          h = a;
          l = 32'hFFFF_FFFF;
        end else begin
          h = a % b;
          l = a / b;
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      4:       return 32'(32'($urandom_range(0, 15)));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && done_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(cyc), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("result_hi", 64'(hi_o), 64'(e.hi));
          chk("result_lo", 64'(lo_o), 64'(e.lo));
          chk("done_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit skip_sync, input bit disturb, input bit wr_lo, input bit wait_done);
    exp_t        e;
    logic [31:0] wv, hprev, lprev;
    bit          fin;
    if (!skip_sync) @(negedge clk);
    start_i = 1'b1;
    op_i    = op;
    data1_i = a;
    data2_i = b;
    wv      = 32'($urandom);
    if (wr_lo) begin
      lo_we_i = 1'b1;
      wdata_i = wv;
    end
    model(op, a, b, e.hi, e.lo);
    e.due = cyc + 33;
    exp_q.push_back(e);
    @(negedge clk);
    start_i = 1'b0;
    lo_we_i = 1'b0;
    op_i    = 2'($urandom);
    data1_i = 32'($urandom);
    data2_i = 32'($urandom);
    chk("busy_after_start", 64'(busy_o), 64'(1));
    if (wr_lo) chk("lo_write_with_start", 64'(lo_o), 64'(wv));
    if (disturb) begin
      hprev = hi_o;
      lprev = lo_o;
      repeat (3) @(negedge clk);
      start_i = 1'b1;
      hi_we_i = 1'b1;
      lo_we_i = 1'b1;
      wdata_i = 32'($urandom);
      @(negedge clk);
      start_i = 1'b0;
      hi_we_i = 1'b0;
      lo_we_i = 1'b0;
      chk("hi_hold_busy", 64'(hi_o), 64'(hprev));
      chk("lo_hold_busy", 64'(lo_o), 64'(lprev));
    end
    if (wait_done) begin
      fin = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (busy_o === 1'b0) begin
          fin = 1'b1;
          break;
        end
      end
      if (!fin) chk("busy_timeout", 64'(busy_o), 64'(0));
    end
  endtask

  initial begin
    start_i = 1'b0;
    op_i    = '0;
    data1_i = '0;
    data2_i = '0;
    hi_we_i = 1'b0;
    lo_we_i = 1'b0;
    wdata_i = '0;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy_o), 64'(0));
    chk("reset_done", 64'(done_o), 64'(0));
    chk("reset_hi", 64'(hi_o), 64'(0));
    chk("reset_lo", 64'(lo_o), 64'(0));

    // First start accepted on the first edge after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 1);
    chk("multu_max_hi", 64'(hi_o), 64'(32'hFFFF_FFFE));
    chk("multu_max_lo", 64'(lo_o), 64'(32'h0000_0001));

    run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 0, 0, 0, 1);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 1);
    run_op(2'd3, 32'd7, 32'd0, 0, 1, 0, 1);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 1);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd0, 0, 0, 0, 1);

    // mtlo / mthi in IDLE.
    @(negedge clk);
    lo_we_i = 1'b1;
    wdata_i = 32'h1234_5678;
    @(negedge clk);
    lo_we_i = 1'b0;
    chk("mtlo_idle", 64'(lo_o), 64'(32'h1234_5678));
    hi_we_i = 1'b1;
    wdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    hi_we_i = 1'b0;
    chk("mthi_idle", 64'(hi_o), 64'(32'hCAFE_F00D));
    chk("mtlo_kept", 64'(lo_o), 64'(32'h1234_5678));

    // Write and start in the same IDLE cycle.
    run_op(2'd1, 32'd6, 32'd7, 0, 0, 1, 1);

    for (int i = 0; i < 24; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 0,
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0), 1);
    end

    // Reset mid-operation aborts it.
    run_op(2'd1, 32'd3, 32'd4, 0, 0, 0, 0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_busy", 64'(busy_o), 64'(0));
    chk("abort_done", 64'(done_o), 64'(0));
    chk("abort_hi", 64'(hi_o), 64'(0));
    chk("abort_lo", 64'(lo_o), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_idle_busy", 64'(busy_o), 64'(0));
    chk("abort_idle_lo", 64'(lo_o), 64'(0));

    run_op(2'd0, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous reset, active low.
REQ-005 start_i  input  1  request a new operation; sampled on clk edges.
REQ-006 op_i  input  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
REQ-007 data1_i  input  32  rs operand: multiplicand or dividend.
REQ-008 data2_i  input  32  rt operand: multiplier or divisor.
REQ-009 hi_we_i  input  1  mthi write enable.
REQ-010 lo_we_i  input  1  mtlo write enable.
REQ-011 wdata_i  input  32  mthi/mtlo write data.
REQ-012 busy_o  output  1  high whenever state is not IDLE.
REQ-013 done_o  output  1  one-cycle pulse marking a completed operation.
REQ-014 hi_o  output  32  HI register (product upper half or remainder).
REQ-015 lo_o  output  32  LO register (product lower half or quotient).

Function
REQ-016 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-017 Transitions SHALL be:
- IDLE->BUSY on start_i=1;
- BUSY->DONE on the edge where the 5-bit iteration counter equals 31;
- DONE->IDLE unconditionally.
REQ-018 On start acceptance, the block SHALL latch op_i, data1_i and data2_i and clear the counter; later changes on these inputs SHALL have no effect on the running operation.
REQ-019 start_i SHALL be ignored in BUSY and DONE; there is no queueing.
REQ-020 BUSY SHALL perform exactly one iteration per cycle for 32 cycles: shift-add for multiply, restoring shift-subtract for divide, each on unsigned magnitudes.
REQ-021 Signed ops (MULT, DIV) SHALL use the two's-complement magnitude of each operand.
- MULT: negate the 64-bit product when the operand signs differ.
- DIV: negate the quotient when the signs differ; the remainder takes the sign of the dividend.
REQ-022 On the BUSY->DONE edge, hi_o/lo_o SHALL load the result. done_o SHALL be high for exactly the one DONE cycle, i.e. in the 33rd cycle after the start-accept edge.
REQ-023 Divide by zero (DIV or DIVU) SHALL give hi_o = dividend and lo_o = 0xFFFFFFFF, with the same 33-cycle latency.
REQ-024 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo_o = 0x80000000 and hi_o = 0; this wraps with no trap.
REQ-025 hi_we_i/lo_we_i SHALL update hi_o/lo_o from wdata_i on the next edge, in IDLE only; they SHALL be ignored in BUSY and DONE.
REQ-026 If start_i and a write enable are both high in IDLE, the write SHALL take effect and the operation SHALL start; the operation's result later overwrites HI/LO.
REQ-027 hi_o/lo_o SHALL hold their values in every cycle not covered by REQ-022 or REQ-025; intermediate iteration state SHALL NOT be visible on them.
REQ-028 All outputs SHALL be driven directly from registers.

Reset
REQ-029 While rst_n=0, the block SHALL immediately force:
- state=IDLE, counter=0;
- busy_o=0, done_o=0;
- hi_o=0, lo_o=0;
- all internal operand and accumulator registers to 0.
REQ-030 A reset asserted mid-operation SHALL abort it: no done_o pulse and no HI/LO update.
REQ-031 The first start_i SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-032 MULTU with 0xFFFFFFFF x 0xFFFFFFFF -> after 33 cycles, done_o=1, hi_o=0xFFFFFFFE, lo_o=0x00000001.
REQ-033 MULT with 0xFFFFFFFD (-3) x 5 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1.
REQ-034 DIV with 0xFFFFFFF9 (-7) / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
REQ-035 DIVU 7 / 0 -> hi_o=7, lo_o=0xFFFFFFFF; a second start_i pulsed during BUSY is ignored, giving exactly one done_o pulse.
REQ-036 mtlo of 0x12345678 in IDLE -> lo_o=0x12345678 the next cycle; a mthi during BUSY leaves hi_o unchanged.
REQ-037 Start MULTU 3 x 4, then drop rst_n at cycle 10 -> busy_o=0, hi_o=lo_o=0, and done_o never asserts.
